cache_mem_responder: RTL and testbench

//  Backing-memory model for the cache's memory-side port (mwrite_en/maddr/mdata/mout).

---
 rtl/cache_mem_responder.sv | 139 +++++++++++++
 tb/tb_cache_mem_responder.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_responder.sv
// Backing-memory model for the cache memory-side port: LINE_SIZE-beat refill/write-back bursts
// after LATENCY idle cycles. Define MEM_STATS_EN to add the rd_lines/wr_lines burst counters.
`ifndef LINE_SIZE
`define LINE_SIZE 4
`endif

module cache_mem_responder #(
  parameter int unsigned LINE_SIZE = `LINE_SIZE,
  parameter int unsigned LATENCY   = 3,
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned IDX_W     = $clog2(MEM_WORDS)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mreq,
  input  logic        mwrite_en,
  input  logic [31:0] maddr,
  input  logic [31:0] mdata,
  output logic        mbusy,
  output logic        mvalid,
  output logic [31:0] mout,
  output logic        mdone
`ifdef MEM_STATS_EN
  ,
  output logic [31:0] rd_lines,
  output logic [31:0] wr_lines
`endif
);

  localparam int unsigned K_W    = (LINE_SIZE > 1) ? $clog2(LINE_SIZE) : 1;
  localparam int unsigned CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned LAT_M1 = (LATENCY == 0) ? 0 : LATENCY - 1;

  localparam logic [IDX_W-1:0] LINE_MASK = IDX_W'(LINE_SIZE - 1);
  localparam logic [K_W-1:0]   K_LAST    = K_W'(LINE_SIZE - 1);

  typedef enum logic [1:0] {StIdle, StWait, StBurst, StDone} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] base_q, base_d;
  logic             wr_q, wr_d;
  logic [K_W-1:0]   k_q, k_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] req_base;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_load;

  logic [31:0] mem [MEM_WORDS];

  // Upper address bits are dropped, so requests wrap modulo MEM_WORDS.
  assign req_base = maddr[IDX_W+1:2] & ~LINE_MASK;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    wr_d    = wr_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (mreq) begin
          base_d  = req_base;
          wr_d    = mwrite_en;
          k_d     = '0;
          cnt_d   = CNT_W'(LAT_M1);
          state_d = (LATENCY == 0) ? StBurst : StWait;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StBurst;
          k_d     = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StBurst: begin
        if (k_q == K_LAST) begin
          state_d = StDone;
        end else begin
          k_d = k_q + K_W'(1);
        end
      end
      StDone: state_d = StIdle;
    endcase
  end

  // Read data is fetched on the edge that enters each beat, so it is valid alongside mvalid.
  assign rd_load = (state_d == StBurst) && !wr_d;
  assign rd_idx  = base_d | IDX_W'(k_d);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      base_q  <= '0;
      wr_q    <= 1'b0;
      k_q     <= '0;
      cnt_q   <= '0;
      mout    <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      wr_q    <= wr_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      if (rd_load) begin
        mout <= mem[rd_idx];
      end
    end
  end

  // Storage is deliberately outside the reset domain; an abort leaves written beats in place.
  always_ff @(posedge clk) begin
    if (state_q == StBurst && wr_q) begin
      mem[base_q | IDX_W'(k_q)] <= mdata;
    end
  end

  assign mbusy  = (state_q != StIdle);
  assign mvalid = (state_q == StBurst);
  assign mdone  = (state_q == StDone);

`ifdef MEM_STATS_EN
  // Counters step on the edge entering DONE, so the new count is visible with mdone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_lines <= '0;
      wr_lines <= '0;
    end else if (state_d == StDone) begin
      if (wr_q) begin
        wr_lines <= wr_lines + 32'd1;
      end else begin
        rd_lines <= rd_lines + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_mem_responder.sv
// Self-checking bench for cache_mem_responder: randomized bursts against an array model of the
// backing store, plus directed timing, back-to-back, wrap, abort and zero-latency scenarios.
`ifndef LINE_SIZE
`define LINE_SIZE 4
`endif

module tb_cache_mem_responder;

  localparam int LS  = `LINE_SIZE;
  localparam int LAT = 3;
  localparam int MW  = 1024;

  logic        clk, reset;
  logic        mreq, mwrite_en;
  logic [31:0] maddr, mdata, mout;
  logic        mbusy, mvalid, mdone;
  logic        z_mreq, z_mwrite_en;
  logic [31:0] z_maddr, z_mdata, z_mout;
  logic        z_mbusy, z_mvalid, z_mdone;
`ifdef MEM_STATS_EN
  logic [31:0] rd_lines, wr_lines, z_rd_lines, z_wr_lines;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model_mem [MW];
  logic [31:0] wbuf [LS];
  logic [31:0] last_mout = '0;
  int unsigned exp_rd = 0;
  int unsigned exp_wr = 0;

  cache_mem_responder #(.LINE_SIZE(LS), .LATENCY(LAT), .MEM_WORDS(MW)) u_dut (
    .clk(clk), .reset(reset), .mreq(mreq), .mwrite_en(mwrite_en), .maddr(maddr),
    .mdata(mdata), .mbusy(mbusy), .mvalid(mvalid), .mout(mout), .mdone(mdone)
`ifdef MEM_STATS_EN
    , .rd_lines(rd_lines), .wr_lines(wr_lines)
`endif
  );

  cache_mem_responder #(.LINE_SIZE(LS), .LATENCY(0), .MEM_WORDS(MW)) u_dut_zl (
    .clk(clk), .reset(reset), .mreq(z_mreq), .mwrite_en(z_mwrite_en), .maddr(z_maddr),
    .mdata(z_mdata), .mbusy(z_mbusy), .mvalid(z_mvalid), .mout(z_mout), .mdone(z_mdone)
`ifdef MEM_STATS_EN
    , .rd_lines(z_rd_lines), .wr_lines(z_wr_lines)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int line_base(input logic [31:0] a);
    return ((int'(a >> 2)) % MW) / LS * LS;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full burst on the LATENCY=3 instance, checked cycle by cycle against the model.
  task automatic run_burst(input bit wr, input logic [31:0] addr, input string name);
    int          b;
    int          last;
    int          k;
    bit          v;
    logic [31:0] exp_out;
    b       = line_base(addr);
    last    = LAT + LS + 1;
    exp_out = last_mout;
    mreq = 1'b1; mwrite_en = wr; maddr = addr;
    step();
    mreq = 1'b0;
    for (int c = 1; c <= last + 1; c++) begin
      v = (c >= LAT + 1) && (c <= LAT + LS);
      k = c - LAT - 1;
      mwrite_en = 1'($urandom);
      maddr     = $urandom;
      if (v && wr) mdata = wbuf[k];
      else mdata = $urandom;
      if (v && !wr) exp_out = model_mem[b + k];
      if (c == last) begin
        if (wr) exp_wr++;
        else exp_rd++;
      end
      n_checks++;
      if ({mbusy, mvalid, mdone} !== {c <= last, v, c == last}) begin
        n_fail++;
        $display("FAIL %s ctl cycle %0d: busy/valid/done got %b%b%b expected %b%b%b", name, c,
                 mbusy, mvalid, mdone, c <= last, v, c == last);
      end
      n_checks++;
      if (mout !== exp_out) begin
        n_fail++;
        $display("FAIL %s mout cycle %0d: got %h expected %h", name, c, mout, exp_out);
      end
`ifdef MEM_STATS_EN
      n_checks++;
      if (rd_lines !== exp_rd || wr_lines !== exp_wr) begin
        n_fail++;
        $display("FAIL %s stats cycle %0d: got rd=%0d wr=%0d expected rd=%0d wr=%0d", name, c,
                 rd_lines, wr_lines, exp_rd, exp_wr);
      end
`endif
      if (v && wr) model_mem[b + k] = wbuf[k];
      step();
    end
    last_mout = exp_out;
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if ({mbusy, mvalid, mdone, mout} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %b%b%b %h expected 000 00000000", mbusy, mvalid, mdone, mout);
    end
    repeat (2) step();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if ({mbusy, mvalid, mdone, mout} !== 35'd0) begin
        n_fail++;
        $display("FAIL idle_after_reset %0d: got %b%b%b %h expected 000 00000000", i,
                 mbusy, mvalid, mdone, mout);
      end
    end
  endtask

  task automatic test_write_read();
    for (int k = 0; k < LS; k++) wbuf[k] = 32'hA0 + k;
    run_burst(1'b1, 32'h40, "write_0x40");
    run_burst(1'b0, 32'h4C, "read_0x4c");
  endtask

  task automatic test_reset_midburst();
    mreq = 1'b1; mwrite_en = 1'b0; maddr = 32'h40;
    step();
    mreq = 1'b0;
    repeat (LAT + 1) step();
    n_checks++;
    if (mvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL midburst_active: mvalid got %b expected 1", mvalid);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if ({mbusy, mvalid, mdone, mout} !== 35'd0) begin
      n_fail++;
      $display("FAIL midburst_reset_async: got %b%b%b %h expected 000 00000000",
               mbusy, mvalid, mdone, mout);
    end
    step();
    reset = 1'b1;
    last_mout = '0; exp_rd = 0; exp_wr = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ({mbusy, mvalid, mdone, mout} !== 35'd0) begin
        n_fail++;
        $display("FAIL midburst_idle %0d: got %b%b%b %h expected 000 00000000", i,
                 mbusy, mvalid, mdone, mout);
      end
    end
  endtask

  task automatic zl_burst(input bit wr, input string name);
    z_mreq = 1'b1; z_mwrite_en = wr; z_maddr = 32'h80;
    step();
    z_mreq = 1'b0; z_mwrite_en = ~wr;
    for (int c = 1; c <= LS + 2; c++) begin
      if (c <= LS && wr) z_mdata = wbuf[c - 1];
      else z_mdata = $urandom;
      n_checks++;
      if ({z_mbusy, z_mvalid, z_mdone} !== {c <= LS + 1, c <= LS, c == LS + 1}) begin
        n_fail++;
        $display("FAIL %s ctl cycle %0d: busy/valid/done got %b%b%b", name, c,
                 z_mbusy, z_mvalid, z_mdone);
      end
      if (!wr && c <= LS) begin
        n_checks++;
        if (z_mout !== wbuf[c - 1]) begin
          n_fail++;
          $display("FAIL %s mout cycle %0d: got %h expected %h", name, c, z_mout, wbuf[c - 1]);
        end
      end
      step();
    end
  endtask

  task automatic test_zero_latency();
    for (int k = 0; k < LS; k++) wbuf[k] = $urandom;
    zl_burst(1'b1, "zl_write");
    zl_burst(1'b0, "zl_read");
  endtask

  task automatic test_preload();
    for (int l = 0; l < MW / LS; l++) begin
      for (int k = 0; k < LS; k++) wbuf[k] = $urandom;
      run_burst(1'b1, 32'(l * LS * 4) | ($urandom & 32'hFFFF_0000), "preload");
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < LS; k++) wbuf[k] = $urandom;
      run_burst(1'($urandom), $urandom, "random");
    end
  endtask

  // mreq held high: requests while busy are ignored, the next starts in the IDLE after DONE.
  task automatic test_back_to_back();
    int p;
    int ph;
    int b;
    bit v;
    p = LAT + LS + 2;
    b = line_base(32'h200);
    mreq = 1'b1; mwrite_en = 1'b0; maddr = 32'h200;
    step();
    for (int c = 1; c <= 2 * p; c++) begin
      ph = (c - 1) % p + 1;
      v  = (ph >= LAT + 1) && (ph <= LAT + LS);
      mwrite_en = (ph == p) ? 1'b0 : 1'($urandom);
      mdata     = $urandom;
      n_checks++;
      if ({mbusy, mvalid, mdone} !== {ph < p, v, ph == LAT + LS + 1}) begin
        n_fail++;
        $display("FAIL b2b ctl cycle %0d: busy/valid/done got %b%b%b expected %b%b%b", c,
                 mbusy, mvalid, mdone, ph < p, v, ph == LAT + LS + 1);
      end
      if (v) begin
        n_checks++;
        if (mout !== model_mem[b + ph - LAT - 1]) begin
          n_fail++;
          $display("FAIL b2b mout cycle %0d: got %h expected %h", c, mout,
                   model_mem[b + ph - LAT - 1]);
        end
      end
      if (c == 2 * p) mreq = 1'b0;
      step();
    end
    exp_rd += 2;
    last_mout = model_mem[b + LS - 1];
  endtask

  task automatic test_wrap_abort();
    int          nb;
    int          b;
    bit          v;
    logic [31:0] addr;
    addr = 32'(MW * 4 + 16);
    b    = line_base(addr);
    nb   = (LS > 2) ? 2 : LS - 1;
    for (int k = 0; k < LS; k++) wbuf[k] = $urandom;
    mreq = 1'b1; mwrite_en = 1'b1; maddr = addr;
    step();
    mreq = 1'b0;
    for (int c = 1; c <= LAT + nb; c++) begin
      v = (c >= LAT + 1);
      if (v) mdata = wbuf[c - LAT - 1];
      else mdata = $urandom;
      n_checks++;
      if ({mbusy, mvalid, mdone} !== {1'b1, v, 1'b0}) begin
        n_fail++;
        $display("FAIL abort ctl cycle %0d: busy/valid/done got %b%b%b", c, mbusy, mvalid, mdone);
      end
      if (v) model_mem[b + c - LAT - 1] = wbuf[c - LAT - 1];
      step();
    end
    mdata = ~wbuf[nb];
    reset = 1'b0;
    #1;
    n_checks++;
    if ({mbusy, mvalid, mdone} !== 3'b000) begin
      n_fail++;
      $display("FAIL abort_reset: busy/valid/done got %b%b%b expected 000", mbusy, mvalid, mdone);
    end
    step();
    reset = 1'b1;
    last_mout = '0; exp_rd = 0; exp_wr = 0;
    for (int i = 0; i < LAT + LS + 2; i++) begin
      n_checks++;
      if ({mbusy, mvalid, mdone} !== 3'b000) begin
        n_fail++;
        $display("FAIL abort_no_done %0d: busy/valid/done got %b%b%b", i, mbusy, mvalid, mdone);
      end
      step();
    end
`ifdef MEM_STATS_EN
    n_checks++;
    if (wr_lines !== 32'd0) begin
      n_fail++;
      $display("FAIL abort_not_counted: wr_lines got %0d expected 0", wr_lines);
    end
`endif
    run_burst(1'b0, 32'h10, "wrap_readback");
  endtask

  task automatic test_stats();
    reset = 1'b0;
    #1;
    reset = 1'b1;
    last_mout = '0; exp_rd = 0; exp_wr = 0;
    step();
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < LS; k++) wbuf[k] = $urandom;
      run_burst(i >= 3, $urandom, "stats");
    end
`ifdef MEM_STATS_EN
    n_checks++;
    if (rd_lines !== 32'd3 || wr_lines !== 32'd2) begin
      n_fail++;
      $display("FAIL stats_total: got rd=%0d wr=%0d expected rd=3 wr=2", rd_lines, wr_lines);
    end
`endif
  endtask

  initial begin
    reset = 1'b0;
    mreq = 1'b0; mwrite_en = 1'b0; maddr = '0; mdata = '0;
    z_mreq = 1'b0; z_mwrite_en = 1'b0; z_maddr = '0; z_mdata = '0;
    for (int i = 0; i < MW; i++) model_mem[i] = '0;
    test_reset();
    test_write_read();
    test_reset_midburst();
    test_zero_latency();
    test_preload();
    test_random();
    test_back_to_back();
    test_wrap_abort();
    test_stats();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
